// File: rtl/uvma_cvmcu_io_pad_chkr_if.sv
// rtl/uvma_cvmcu_io_pad_chkr_if.sv - pad bank signals watched by the IO pad checker
interface uvma_cvmcu_io_pad_chkr_if #(
  parameter int NUM_IO = 48
) ();
  logic [NUM_IO-1:0] io_out;
  logic [NUM_IO-1:0] io_oe;
  logic [NUM_IO-1:0] io_in;

  modport master (output io_out, output io_oe, output io_in);
  modport slave  (input  io_out, input  io_oe, input  io_in);
endinterface

// File: rtl/uvma_cvmcu_io_pad_chkr.sv
// rtl/uvma_cvmcu_io_pad_chkr.sv - IO pad glitch/contention checker; UVMA_CVMCU_IO_PAD_CHKR_ASSERT_EN adds assertions and covers
module uvma_cvmcu_io_pad_chkr #(
  parameter int NUM_IO         = 48,
  parameter int SETTLE_CYCLES  = 2,
  parameter int CONTEND_CYCLES = 3,
  parameter int CNT_W          = 16
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic                                        chk_en,
  input  logic                                        viol_clr,
  uvma_cvmcu_io_pad_chkr_if.slave                     pad,
  output logic                                        viol_pulse,
  output logic [NUM_IO-1:0]                           viol_sticky,
  output logic [CNT_W-1:0]                            viol_cnt,
  output logic                                        first_vld,
  output logic [((NUM_IO > 1) ? $clog2(NUM_IO) : 1)-1:0] first_idx,
  output logic [1:0]                                  first_type
);

  localparam int IDX_W = (NUM_IO > 1) ? $clog2(NUM_IO) : 1;
  localparam int PC_W  = $clog2(NUM_IO + 1);
  localparam int SUM_W = CNT_W + PC_W;
  localparam logic [3:0] SETTLE_M1  = 4'(SETTLE_CYCLES - 1);
  localparam logic [3:0] CONTEND_M1 = 4'(CONTEND_CYCLES - 1);
  localparam logic [3:0] CONTEND_SAT = 4'(CONTEND_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {ST_OFF = 2'd0, ST_SETTLE = 2'd1, ST_DRIVE = 2'd2} state_t;

  state_t            state_q  [NUM_IO];
  state_t            state_d  [NUM_IO];
  logic [3:0]        settle_q [NUM_IO];
  logic [3:0]        settle_d [NUM_IO];
  logic [3:0]        mis_q    [NUM_IO];
  logic [3:0]        mis_d    [NUM_IO];
  logic [NUM_IO-1:0] prev_out;
  logic [NUM_IO-1:0] mism;
  logic [NUM_IO-1:0] glitch;
  logic [NUM_IO-1:0] contend;
  logic [NUM_IO-1:0] viol_any;

  assign mism     = pad.io_in ^ pad.io_out;
  assign viol_any = glitch | contend;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_IO; i++) begin
        state_q[i]  <= ST_OFF;
        settle_q[i] <= '0;
        mis_q[i]    <= '0;
      end
      prev_out <= '0;
    end else begin
      for (int i = 0; i < NUM_IO; i++) begin
        state_q[i]  <= state_d[i];
        settle_q[i] <= settle_d[i];
        mis_q[i]    <= mis_d[i];
      end
      prev_out <= pad.io_out;
    end
  end

  // Mismatch count saturates one past the trigger value so a long episode fires only once.
  always_comb begin
    for (int i = 0; i < NUM_IO; i++) begin
      state_d[i]  = state_q[i];
      settle_d[i] = settle_q[i];
      mis_d[i]    = mis_q[i];
      if (!chk_en || !pad.io_oe[i]) begin
        state_d[i]  = ST_OFF;
        settle_d[i] = '0;
        mis_d[i]    = '0;
      end else begin
        case (state_q[i])
          ST_OFF: begin
            state_d[i]  = ST_SETTLE;
            settle_d[i] = SETTLE_M1;
            mis_d[i]    = '0;
          end
          ST_SETTLE: begin
            if (settle_q[i] == 4'd0) begin
              state_d[i] = ST_DRIVE;
              mis_d[i]   = '0;
            end else begin
              settle_d[i] = settle_q[i] - 4'd1;
            end
          end
          ST_DRIVE: begin
            if (!mism[i])                      mis_d[i] = '0;
            else if (mis_q[i] != CONTEND_SAT)  mis_d[i] = mis_q[i] + 4'd1;
          end
          default: begin
            state_d[i]  = ST_OFF;
            settle_d[i] = '0;
            mis_d[i]    = '0;
          end
        endcase
      end
    end
  end

  always_comb begin
    glitch  = '0;
    contend = '0;
    for (int i = 0; i < NUM_IO; i++) begin
      glitch[i]  = chk_en && pad.io_oe[i] && (state_q[i] == ST_SETTLE) &&
                   (pad.io_out[i] != prev_out[i]);
      contend[i] = chk_en && pad.io_oe[i] && (state_q[i] == ST_DRIVE) &&
                   mism[i] && (mis_q[i] == CONTEND_M1);
    end
  end

  logic [PC_W-1:0]  pop;
  logic [CNT_W-1:0] cnt_base;
  logic [SUM_W-1:0] sum;
  logic [CNT_W-1:0] cnt_d;
  logic [IDX_W-1:0] idx_d;
  logic [1:0]       type_d;

  // Clear is applied before this cycle's violations are folded in.
  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_IO; i++) pop = pop + PC_W'(viol_any[i]);
    cnt_base = viol_clr ? '0 : viol_cnt;
    sum      = SUM_W'(cnt_base) + SUM_W'(pop);
    cnt_d    = (|sum[SUM_W-1:CNT_W]) ? CNT_MAX : sum[CNT_W-1:0];
    idx_d    = '0;
    type_d   = '0;
    for (int i = NUM_IO - 1; i >= 0; i--) begin
      if (viol_any[i]) begin
        idx_d  = IDX_W'(i);
        type_d = {contend[i], glitch[i]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      viol_pulse  <= 1'b0;
      viol_sticky <= '0;
      viol_cnt    <= '0;
      first_vld   <= 1'b0;
      first_idx   <= '0;
      first_type  <= '0;
    end else begin
      viol_pulse  <= |viol_any;
      viol_sticky <= (viol_clr ? '0 : viol_sticky) | viol_any;
      viol_cnt    <= cnt_d;
      if ((viol_clr || !first_vld) && (|viol_any)) begin
        first_vld  <= 1'b1;
        first_idx  <= idx_d;
        first_type <= type_d;
      end else if (viol_clr) begin
        first_vld  <= 1'b0;
        first_idx  <= '0;
        first_type <= '0;
      end
    end
  end

`ifdef UVMA_CVMCU_IO_PAD_CHKR_ASSERT_EN
  for (genvar g = 0; g < NUM_IO; g++) begin : g_chk
    a_no_viol: assert property (@(posedge clk) disable iff (reset) !viol_any[g])
      else $error("io pad violation ch %0d type %b", g, {contend[g], glitch[g]});
    c_drive: cover property (@(posedge clk) disable iff (reset) state_q[g] == ST_DRIVE);
  end
`endif

endmodule
